// File: rtl/classifier_seq.sv
// Sequencer for the INT4xINT8 classifier MAC/argmax datapath: streams every
// (feature, class) operand pair into the MAC, flushes, then captures the argmax result.
module classifier_seq #(
   parameter int unsigned N_FEAT     = 64,
   parameter int unsigned N_CLASS    = 8,
   parameter int unsigned CLASS_BITS = 3,
   parameter int unsigned FEAT_AW    = $clog2(N_FEAT),
   parameter int unsigned W_AW       = $clog2(N_CLASS * N_FEAT),
   parameter int unsigned RES_LAT    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic [FEAT_AW-1:0]    feat_addr,
   input  logic [3:0]            feat_rdata,
   output logic [W_AW-1:0]       w_addr,
   input  logic [7:0]            w_rdata,
   output logic [3:0]            x_int4,
   output logic [7:0]            w_int8,
   output logic                  new_feat,
   output logic                  new_class,
   output logic [CLASS_BITS-1:0] class_id,
   input  logic [19:0]           max_score,
   input  logic [CLASS_BITS-1:0] max_class,
   output logic [19:0]           res_score,
   output logic [CLASS_BITS-1:0] res_class
);

   localparam int unsigned K      = N_CLASS * N_FEAT;
   localparam int unsigned WAIT_W = (RES_LAT > 1) ? $clog2(RES_LAT) : 1;

   typedef enum logic [2:0] {IDLE, RUN, FLUSH, WAIT, DONE} state_t;

   state_t                state;
   logic                  issue;
   logic [CLASS_BITS-1:0] class_cnt;
   logic                  s1_valid;
   logic                  s1_first;
   logic [CLASS_BITS-1:0] s1_class;
   logic [WAIT_W-1:0]     wait_cnt;

   // feat_addr doubles as the feature counter; w_addr runs linearly across all beats.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         issue     <= 1'b0;
         feat_addr <= '0;
         w_addr    <= '0;
         class_cnt <= '0;
         s1_valid  <= 1'b0;
         s1_first  <= 1'b0;
         s1_class  <= '0;
         x_int4    <= '0;
         w_int8    <= '0;
         new_feat  <= 1'b0;
         new_class <= 1'b0;
         class_id  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         wait_cnt  <= '0;
         res_score <= '0;
         res_class <= '0;
      end else if (abort && state != IDLE) begin
         state     <= IDLE;
         issue     <= 1'b0;
         feat_addr <= '0;
         w_addr    <= '0;
         class_cnt <= '0;
         s1_valid  <= 1'b0;
         s1_first  <= 1'b0;
         s1_class  <= '0;
         x_int4    <= '0;
         w_int8    <= '0;
         new_feat  <= 1'b0;
         new_class <= 1'b0;
         class_id  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         wait_cnt  <= '0;
      end else begin
         // S0: address issue
         if (issue) begin
            if (w_addr == W_AW'(K - 1)) begin
               issue     <= 1'b0;
               w_addr    <= '0;
               feat_addr <= '0;
               class_cnt <= '0;
            end else begin
               w_addr <= w_addr + W_AW'(1);
               if (feat_addr == FEAT_AW'(N_FEAT - 1)) begin
                  feat_addr <= '0;
                  class_cnt <= class_cnt + CLASS_BITS'(1);
               end else begin
                  feat_addr <= feat_addr + FEAT_AW'(1);
               end
            end
         end

         // S1: tags travel alongside the memory read
         s1_valid <= issue;
         s1_first <= issue && (feat_addr == '0);
         s1_class <= class_cnt;

         // S2: registered MAC operands, zero when no beat is in flight
         new_feat  <= s1_valid;
         new_class <= s1_valid & s1_first;
         class_id  <= s1_valid ? s1_class : '0;
         x_int4    <= s1_valid ? feat_rdata : '0;
         w_int8    <= s1_valid ? w_rdata : '0;
         done      <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  busy  <= 1'b1;
                  issue <= 1'b1;
               end
            end
            RUN: begin
               // last operands are on the MAC bus now; next cycle is the flush strobe
               if (!issue && !s1_valid) begin
                  state     <= FLUSH;
                  new_class <= 1'b1;
                  class_id  <= '0;
               end
            end
            FLUSH: begin
               state    <= WAIT;
               wait_cnt <= '0;
            end
            WAIT: begin
               if (wait_cnt == WAIT_W'(RES_LAT - 1)) begin
                  state     <= DONE;
                  res_score <= max_score;
                  res_class <= max_class;
                  done      <= 1'b1;
                  busy      <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
